sdram_frame_writer: RTL and testbench

SDRAM_FRAME_WRITER -- requirements
Module: sdram_frame_writer

---
 rtl/sdram_frame_writer.sv | 199 +++++++++++++++++++
 tb/tb_sdram_frame_writer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_frame_writer.sv
// Packs pixel bytes from a FIFO into 16-bit words and writes iNUM_IMAGES frames of
// FRAME_PIXELS bytes to SDRAM. Define SDRAM_FRAME_WRITER_CHECKSUM_EN for a per-frame byte sum.
module sdram_frame_writer #(
    parameter int unsigned FRAME_PIXELS = 786432,
    parameter logic [22:0] BASE_ADDR    = 23'h0
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iTRIGGER,
    input  logic [6:0]  iNUM_IMAGES,
    output logic        oFIFO_RDREQ,
    input  logic [7:0]  iFIFO_DATA,
    input  logic        iFIFO_EMPTY,
    output logic        oWR_REQ,
    output logic [22:0] oWR_ADDR,
    output logic [15:0] oWR_DATA,
    input  logic        iWR_WAIT,
    output logic        oBUSY,
    output logic        oDONE,
    output logic [6:0]  oFRAME_IDX,
    output logic        oERROR,
    output logic [15:0] oCHECKSUM
);
    localparam int unsigned     HALF      = FRAME_PIXELS / 2;
    localparam int unsigned     WCW       = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [WCW-1:0]  LAST_WORD = WCW'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH_LO = 3'd1,
        CAP_LO   = 3'd2,
        FETCH_HI = 3'd3,
        CAP_HI   = 3'd4,
        WRITE    = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       count_q, count_d;
    logic [6:0]       frame_idx_q, frame_idx_d;
    logic [WCW-1:0]   word_cnt_q, word_cnt_d;
    logic [22:0]      addr_q, addr_d;
    logic [15:0]      data_q, data_d;
    logic             error_q, error_d;

    logic num_ok_s;
    logic accept_s;
    logic frame_end_s;
    logic last_frame_s;

    assign num_ok_s     = (iNUM_IMAGES != 7'd0) && (iNUM_IMAGES <= 7'd64);
    assign accept_s     = (state_q == WRITE) && !iWR_WAIT;
    assign frame_end_s  = (word_cnt_q == LAST_WORD);
    assign last_frame_s = ((frame_idx_q + 7'd1) == count_q);

    // State and datapath registers
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= IDLE;
            count_q     <= 7'd0;
            frame_idx_q <= 7'd0;
            word_cnt_q  <= '0;
            addr_q      <= 23'd0;
            data_q      <= 16'd0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            frame_idx_q <= frame_idx_d;
            word_cnt_q  <= word_cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            error_q     <= error_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (iTRIGGER && num_ok_s) state_d = FETCH_LO;
                else                      state_d = IDLE;
            end
            FETCH_LO: begin
                if (!iFIFO_EMPTY) state_d = CAP_LO;
                else              state_d = FETCH_LO;
            end
            CAP_LO:   state_d = FETCH_HI;
            FETCH_HI: begin
                if (!iFIFO_EMPTY) state_d = CAP_HI;
                else              state_d = FETCH_HI;
            end
            CAP_HI:   state_d = WRITE;
            WRITE: begin
                if (accept_s && frame_end_s && last_frame_s) state_d = DONE;
                else if (accept_s)                           state_d = FETCH_LO;
                else                                         state_d = WRITE;
            end
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Counters, address and data word; the address advances incrementally, no multiply
    always_comb begin
        count_d     = count_q;
        frame_idx_d = frame_idx_q;
        word_cnt_d  = word_cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        case (state_q)
            IDLE: begin
                if (iTRIGGER && num_ok_s) begin
                    count_d     = iNUM_IMAGES;
                    frame_idx_d = 7'd0;
                    word_cnt_d  = '0;
                    addr_d      = BASE_ADDR;
                end else begin
                    count_d     = count_q;
                end
            end
            CAP_LO:  data_d[7:0]  = iFIFO_DATA;
            CAP_HI:  data_d[15:8] = iFIFO_DATA;
            WRITE: begin
                if (accept_s) begin
                    addr_d = addr_q + 23'd1;
                    if (frame_end_s) begin
                        word_cnt_d  = '0;
                        frame_idx_d = frame_idx_q + 7'd1;
                    end else begin
                        word_cnt_d  = word_cnt_q + WCW'(1'b1);
                    end
                end else begin
                    addr_d = addr_q;
                end
            end
            default: data_d = data_q;
        endcase
    end

    // Sticky error: a bad count in IDLE or any trigger while busy; a good trigger clears it
    always_comb begin
        if (iTRIGGER) begin
            if ((state_q != IDLE) || !num_ok_s) error_d = 1'b1;
            else                                error_d = 1'b0;
        end else begin
            error_d = error_q;
        end
    end

    // Output decode
    always_comb begin
        oFIFO_RDREQ = 1'b0;
        oWR_REQ     = 1'b0;
        oBUSY       = 1'b1;
        oDONE       = 1'b0;
        case (state_q)
            IDLE:               oBUSY       = 1'b0;
            FETCH_LO, FETCH_HI: oFIFO_RDREQ = !iFIFO_EMPTY;
            WRITE:              oWR_REQ     = 1'b1;
            DONE:               oDONE       = 1'b1;
            default:            oBUSY       = 1'b1;
        endcase
    end

    assign oWR_ADDR   = addr_q;
    assign oWR_DATA   = data_q;
    assign oFRAME_IDX = frame_idx_q;
    assign oERROR     = error_q;

`ifdef SDRAM_FRAME_WRITER_CHECKSUM_EN
    logic [15:0] checksum_q, checksum_d;

    // First low byte of a frame restarts the sum, so the previous total stays visible until then
    always_comb begin
        checksum_d = checksum_q;
        case (state_q)
            CAP_LO: begin
                if (word_cnt_q == '0) checksum_d = {8'h00, iFIFO_DATA};
                else                  checksum_d = checksum_q + {8'h00, iFIFO_DATA};
            end
            CAP_HI:  checksum_d = checksum_q + {8'h00, iFIFO_DATA};
            default: checksum_d = checksum_q;
        endcase
    end

    // Checksum register
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) checksum_q <= 16'h0000;
        else      checksum_q <= checksum_d;
    end

    assign oCHECKSUM = checksum_q;
`else
    assign oCHECKSUM = 16'h0000;
`endif

endmodule

// File: tb/tb_sdram_frame_writer.sv
// Bench for sdram_frame_writer: instance A (8 pixels, base 0x100) and B (4 pixels, base 0)
// share one FIFO model; sel picks the active instance. Writes are scoreboarded.
module tb_sdram_frame_writer;
    logic        clk = 1'b0;
    logic        rst;
    logic        sel, trig, stall, wr_wait;
    logic [6:0]  num;
    logic [7:0]  fbytes [0:255];
    int          wr_ptr;
    int          rd_ptr   = 0;
    int          rd_bad   = 0;
    int          done_cnt = 0;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_empty;
    logic [45:0] exp_q[$];
    logic [45:0] obs_q[$];
    int          tests_run, tests_failed;

    always #5 clk = ~clk;

    assign fifo_empty = stall || (rd_ptr >= wr_ptr);

    logic a_rdreq, a_wr_req, a_busy, a_done, a_err;
    logic b_rdreq, b_wr_req, b_busy, b_done, b_err;
    logic [22:0] a_addr, b_addr;
    logic [15:0] a_data, b_data, a_sum, b_sum;
    logic [6:0]  a_idx, b_idx;

    sdram_frame_writer #(.FRAME_PIXELS(8), .BASE_ADDR(23'h100)) u_dut_a (
        .iCLK(clk), .iRST(rst), .iTRIGGER(trig & ~sel), .iNUM_IMAGES(num),
        .oFIFO_RDREQ(a_rdreq), .iFIFO_DATA(fifo_data), .iFIFO_EMPTY(fifo_empty | sel),
        .oWR_REQ(a_wr_req), .oWR_ADDR(a_addr), .oWR_DATA(a_data), .iWR_WAIT(wr_wait),
        .oBUSY(a_busy), .oDONE(a_done), .oFRAME_IDX(a_idx), .oERROR(a_err), .oCHECKSUM(a_sum));

    sdram_frame_writer #(.FRAME_PIXELS(4), .BASE_ADDR(23'h0)) u_dut_b (
        .iCLK(clk), .iRST(rst), .iTRIGGER(trig & sel), .iNUM_IMAGES(num),
        .oFIFO_RDREQ(b_rdreq), .iFIFO_DATA(fifo_data), .iFIFO_EMPTY(fifo_empty | ~sel),
        .oWR_REQ(b_wr_req), .oWR_ADDR(b_addr), .oWR_DATA(b_data), .iWR_WAIT(wr_wait),
        .oBUSY(b_busy), .oDONE(b_done), .oFRAME_IDX(b_idx), .oERROR(b_err), .oCHECKSUM(b_sum));

    logic c_rdreq, c_wr_req, c_busy, c_done, c_err;
    logic [22:0] c_addr;
    logic [15:0] c_data, c_sum;
    logic [6:0]  c_idx;
    assign c_rdreq  = sel ? b_rdreq  : a_rdreq;
    assign c_wr_req = sel ? b_wr_req : a_wr_req;
    assign c_busy   = sel ? b_busy   : a_busy;
    assign c_done   = sel ? b_done   : a_done;
    assign c_err    = sel ? b_err    : a_err;
    assign c_addr   = sel ? b_addr   : a_addr;
    assign c_data   = sel ? b_data   : a_data;
    assign c_sum    = sel ? b_sum    : a_sum;
    assign c_idx    = sel ? b_idx    : a_idx;

    // FIFO model and write/done monitor
    always @(posedge clk) begin
        if (c_rdreq) begin
            if (fifo_empty) rd_bad <= rd_bad + 1;
            else begin
                fifo_data <= fbytes[rd_ptr[7:0]];
                rd_ptr    <= rd_ptr + 1;
            end
        end
        if (c_wr_req && !wr_wait) obs_q.push_back({c_idx, c_addr, c_data});
        if (c_done) done_cnt <= done_cnt + 1;
    end

    task automatic load(input logic [7:0] b);
        fbytes[wr_ptr[7:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Reference: word w of frame f sits at base + f*half + w, low byte first
    task automatic model_push(input logic [22:0] base, input int half, input int frames,
                              input int start, output logic [15:0] last_sum);
        logic [15:0] s;
        int p;
        p = start;
        last_sum = 16'h0000;
        for (int f = 0; f < frames; f++) begin
            s = 16'h0000;
            for (int w = 0; w < half; w++) begin
                exp_q.push_back({7'(f), base + 23'(f * half + w), fbytes[8'(p + 1)], fbytes[8'(p)]});
                s = s + {8'h00, fbytes[8'(p)]} + {8'h00, fbytes[8'(p + 1)]};
                p = p + 2;
            end
            last_sum = s;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; sel = 1'b0; trig = 1'b0; num = 7'd0; stall = 1'b0; wr_wait = 1'b0;
        for (int i = 1; i <= 8; i++) load(8'(i));
        repeat (3) @(negedge clk);
        tests_run++;
        if ({a_rdreq, a_wr_req, a_busy, a_done, a_err} !== 5'b00000) begin
            tests_failed++; $display("FAIL reset_ctrl: got %b want 00000", {a_rdreq, a_wr_req, a_busy, a_done, a_err});
        end
        tests_run++;
        if ({a_addr, a_data, a_idx, a_sum} !== 62'h0) begin
            tests_failed++; $display("FAIL reset_data: got addr=%h data=%h idx=%0d sum=%h want 0", a_addr, a_data, a_idx, a_sum);
        end
        rst = 1'b0;
        repeat (6) @(negedge clk);
        tests_run++;
        if (rd_ptr !== 0 || obs_q.size() !== 0 || a_busy !== 1'b0) begin
            tests_failed++; $display("FAIL reset_quiet: got reads=%0d writes=%0d busy=%b want 0 0 0", rd_ptr, obs_q.size(), a_busy);
        end
    endtask

    task automatic test_single;
        logic [45:0] e, o;
        int cyc, d0, r0;
        exp_q.push_back({7'd0, 23'h100, 16'h0201});
        exp_q.push_back({7'd0, 23'h101, 16'h0403});
        exp_q.push_back({7'd0, 23'h102, 16'h0605});
        exp_q.push_back({7'd0, 23'h103, 16'h0807});
        d0 = done_cnt; r0 = rd_ptr;
        @(negedge clk); num = 7'd1; trig = 1'b1;
        cyc = 0;
        do begin @(negedge clk); trig = 1'b0; cyc++; end while (!c_done && cyc < 200);
        tests_run++;
        if (cyc > 21) begin tests_failed++; $display("FAIL single_latency: got %0d cycles want <= 21", cyc); end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL single_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL single_write: got idx=%0d addr=%h data=%h want idx=%0d addr=%h data=%h", o[45:39], o[38:16], o[15:0], e[45:39], e[38:16], e[15:0]); end
        end
        exp_q.delete(); obs_q.delete();
        repeat (2) @(negedge clk);
        tests_run++;
        if (done_cnt - d0 != 1 || c_busy !== 1'b0 || rd_ptr - r0 != 8) begin
            tests_failed++; $display("FAIL single_end: got done=%0d busy=%b reads=%0d want 1 0 8", done_cnt - d0, c_busy, rd_ptr - r0);
        end
        tests_run++;
`ifdef SDRAM_FRAME_WRITER_CHECKSUM_EN
        if (c_sum !== 16'h0024) begin tests_failed++; $display("FAIL single_sum: got %h want 0024", c_sum); end
`else
        if (c_sum !== 16'h0000) begin tests_failed++; $display("FAIL single_sum: got %h want 0000", c_sum); end
`endif
    endtask

    task automatic test_multi;
        logic [45:0] e, o;
        logic [15:0] s;
        int cyc, d0, start;
        @(negedge clk); sel = 1'b1;
        start = wr_ptr;
        for (int i = 0; i < 12; i++) load(8'($urandom_range(0, 255)));
        model_push(23'h0, 2, 3, start, s);
        d0 = done_cnt;
        @(negedge clk); num = 7'd3; trig = 1'b1;
        cyc = 0;
        do begin @(negedge clk); trig = 1'b0; cyc++; end while (!c_done && cyc < 300);
        tests_run++;
        if (!c_done || obs_q.size() != 6) begin tests_failed++; $display("FAIL multi_done: got done=%b writes=%0d want 1 6", c_done, obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL multi_write: got idx=%0d addr=%h data=%h want idx=%0d addr=%h data=%h", o[45:39], o[38:16], o[15:0], e[45:39], e[38:16], e[15:0]); end
        end
        exp_q.delete(); obs_q.delete();
        repeat (2) @(negedge clk);
        tests_run++;
        if (done_cnt - d0 != 1) begin tests_failed++; $display("FAIL multi_pulses: got %0d want 1", done_cnt - d0); end
        tests_run++;
`ifdef SDRAM_FRAME_WRITER_CHECKSUM_EN
        if (c_sum !== s) begin tests_failed++; $display("FAIL multi_sum: got %h want %h", c_sum, s); end
`else
        if (c_sum !== 16'h0000) begin tests_failed++; $display("FAIL multi_sum: got %h want 0000 (sum %h unused)", c_sum, s); end
`endif
    endtask

    task automatic test_wait;
        logic [45:0] e, o;
        logic [22:0] ha;
        logic [15:0] hd, s;
        int cyc, k, unstable, hr, start;
        @(negedge clk); sel = 1'b0;
        start = wr_ptr;
        for (int i = 1; i <= 8; i++) load(8'h A0 + 8'(i));
        model_push(23'h100, 4, 1, start, s);
        wr_wait = 1'b1;
        k = 0; unstable = 0; ha = 23'h0; hd = 16'h0; hr = 0;
        @(negedge clk); num = 7'd1; trig = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk); trig = 1'b0; cyc++;
            if (c_wr_req && wr_wait) begin
                k++;
                if (k == 1) begin ha = c_addr; hd = c_data; hr = rd_ptr; end
                else if (c_addr !== ha || c_data !== hd || rd_ptr != hr) unstable++;
                if (k == 6) wr_wait = 1'b0;
            end
        end while (!c_done && cyc < 300);
        wr_wait = 1'b0;
        tests_run++;
        if (k != 6 || unstable != 0) begin tests_failed++; $display("FAIL wait_hold: got held=%0d unstable=%0d want 6 0", k, unstable); end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL wait_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL wait_write: got addr=%h data=%h want addr=%h data=%h", o[38:16], o[15:0], e[38:16], e[15:0]); end
        end
        exp_q.delete(); obs_q.delete();
        tests_run++;
        if (rd_ptr - start != 8) begin tests_failed++; $display("FAIL wait_reads: got %0d want 8", rd_ptr - start); end
    endtask

    task automatic test_stall;
        logic [45:0] e, o;
        int cyc, scnt, last_rd, bad, rb0;
        @(negedge clk);
        for (int i = 1; i <= 8; i++) load(8'(i));
        exp_q.push_back({7'd0, 23'h100, 16'h0201});
        exp_q.push_back({7'd0, 23'h101, 16'h0403});
        exp_q.push_back({7'd0, 23'h102, 16'h0605});
        exp_q.push_back({7'd0, 23'h103, 16'h0807});
        last_rd = rd_ptr; rb0 = rd_bad; scnt = 0; bad = 0;
        num = 7'd1; trig = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk); trig = 1'b0; cyc++;
            if (rd_ptr != last_rd) begin last_rd = rd_ptr; stall = 1'b1; scnt = 10; end
            else if (scnt > 0) begin scnt--; if (scnt == 0) stall = 1'b0; end
            if (stall && c_rdreq) bad++;
        end while (!c_done && cyc < 400);
        stall = 1'b0;
        tests_run++;
        if (bad != 0 || rd_bad != rb0 || !c_done) begin tests_failed++; $display("FAIL stall_rdreq: got bad=%0d empty_reads=%0d done=%b want 0 0 1", bad, rd_bad - rb0, c_done); end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL stall_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL stall_write: got addr=%h data=%h want addr=%h data=%h", o[38:16], o[15:0], e[38:16], e[15:0]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_errors;
        logic [45:0] e, o;
        logic [15:0] s;
        int cyc, d0, r0, start;
        @(negedge clk); r0 = rd_ptr;
        for (int i = 0; i < 8; i++) load(8'h30 + 8'(i));
        num = 7'd0; trig = 1'b1;
        @(negedge clk); trig = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (c_err !== 1'b1 || c_busy !== 1'b0 || rd_ptr != r0) begin
            tests_failed++; $display("FAIL err_zero: got err=%b busy=%b reads=%0d want 1 0 0", c_err, c_busy, rd_ptr - r0);
        end
        start = r0;
        model_push(23'h100, 4, 1, start, s);
        d0 = done_cnt;
        num = 7'd1; trig = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk); cyc++;
            trig = (cyc == 6);
            if (cyc == 2) begin
                tests_run++;
                if (c_err !== 1'b0 || c_busy !== 1'b1) begin tests_failed++; $display("FAIL err_clear: got err=%b busy=%b want 0 1", c_err, c_busy); end
            end
            if (cyc == 7) begin
                tests_run++;
                if (c_err !== 1'b1 || c_busy !== 1'b1) begin tests_failed++; $display("FAIL err_busy_trig: got err=%b busy=%b want 1 1", c_err, c_busy); end
            end
        end while (!c_done && cyc < 300);
        trig = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (done_cnt - d0 != 1 || c_err !== 1'b1) begin tests_failed++; $display("FAIL err_complete: got done=%0d err=%b want 1 1", done_cnt - d0, c_err); end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL err_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL err_write: got addr=%h data=%h want addr=%h data=%h", o[38:16], o[15:0], e[38:16], e[15:0]); end
        end
        exp_q.delete(); obs_q.delete();
        r0 = rd_ptr; load(8'h55); load(8'h66);
        num = 7'd65; trig = 1'b1;
        @(negedge clk); trig = 1'b0;
        repeat (4) @(negedge clk);
        tests_run++;
        if (c_err !== 1'b1 || c_busy !== 1'b0 || rd_ptr != r0) begin
            tests_failed++; $display("FAIL err_65: got err=%b busy=%b reads=%0d want 1 0 0", c_err, c_busy, rd_ptr - r0);
        end
    endtask

    task automatic test_reset_mid;
        logic [45:0] e, o;
        logic [15:0] s;
        int cyc, start, r0;
        @(negedge clk); sel = 1'b1;
        start = rd_ptr;
        while (wr_ptr > start) wr_ptr = wr_ptr - 1;
        load(8'h11); load(8'h22); load(8'h33); load(8'h44);
        load(8'hFF); load(8'hFF); load(8'h02); load(8'h00);
        model_push(23'h0, 2, 1, start, s);
        num = 7'd2; trig = 1'b1;
        cyc = 0;
        do begin @(negedge clk); trig = 1'b0; cyc++; end while (obs_q.size() < 2 && cyc < 200);
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({c_rdreq, c_wr_req, c_busy, c_done, c_err} !== 5'b00000) begin
            tests_failed++; $display("FAIL midrst_ctrl: got %b want 00000", {c_rdreq, c_wr_req, c_busy, c_done, c_err});
        end
        tests_run++;
        if ({c_addr, c_data, c_idx, c_sum} !== 62'h0) begin
            tests_failed++; $display("FAIL midrst_data: got addr=%h data=%h idx=%0d sum=%h want 0", c_addr, c_data, c_idx, c_sum);
        end
        rst = 1'b0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL midrst_write: got addr=%h data=%h want addr=%h data=%h", o[38:16], o[15:0], e[38:16], e[15:0]); end
        end
        exp_q.delete(); obs_q.delete();
        r0 = rd_ptr;
        repeat (5) @(negedge clk);
        tests_run++;
        if (rd_ptr != r0 || obs_q.size() != 0 || r0 - start != 4) begin
            tests_failed++; $display("FAIL midrst_quiet: got reads=%0d writes=%0d consumed=%0d want 0 0 4", rd_ptr - r0, obs_q.size(), r0 - start);
        end
        exp_q.push_back({7'd0, 23'h0, 16'hFFFF});
        exp_q.push_back({7'd0, 23'h1, 16'h0002});
        num = 7'd1; trig = 1'b1;
        cyc = 0;
        do begin @(negedge clk); trig = 1'b0; cyc++; end while (!c_done && cyc < 200);
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL retrig_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL retrig_write: got addr=%h data=%h want addr=%h data=%h", o[38:16], o[15:0], e[38:16], e[15:0]); end
        end
        exp_q.delete(); obs_q.delete();
        @(negedge clk);
        tests_run++;
`ifdef SDRAM_FRAME_WRITER_CHECKSUM_EN
        if (c_sum !== 16'h0200) begin tests_failed++; $display("FAIL retrig_sum: got %h want 0200", c_sum); end
`else
        if (c_sum !== 16'h0000) begin tests_failed++; $display("FAIL retrig_sum: got %h want 0000", c_sum); end
`endif
    endtask

    initial begin
        tests_run = 0; tests_failed = 0; wr_ptr = 0;
        test_reset();
        test_single();
        test_multi();
        test_wait();
        test_stall();
        test_errors();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
